// File: rtl/reset_sequencer.sv
// Reset controller: async key assertion, synchronised release, programmable hold, then
// staggered per-domain release (reset[0] first). soft_req re-runs hold + stagger.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_RESETS  = 3,
  parameter int STAGGER     = 4
) (
  input  logic                  clk,
  input  logic                  key,
  input  logic                  soft_req,
  output logic [NUM_RESETS-1:0] reset,
  output logic                  ready
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(NUM_RESETS + 1);

  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAG_END  = (STAGGER > 0) ? CW'(STAGGER - 1) : '0;
  localparam logic [DW-1:0] DOM_LAST  = DW'(NUM_RESETS - 1);
  localparam bit            STAGGERED = (STAGGER > 0) && (NUM_RESETS > 1);

  typedef enum logic [1:0] {SYNC, HOLD, STAG, RUN} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [DW-1:0]          dom_q;
  logic [NUM_RESETS-1:0]  reset_q;
  logic                   ready_q;

  logic                   sync_busy;
  logic [CW-1:0]          hold_cur;
  logic                   hold_done;

  // NOTE: key is the only async input, so it clears every flop directly; the synchroniser
  // only shapes its release, never its assertion.
  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      sync_q <= '1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_busy = sync_q[SYNC_STAGES-1];

  // The edge that leaves SYNC is already the first hold cycle after the synchronised release,
  // so it counts as 1; in HOLD the counter carries the cycles since the release or soft drop.
  always_comb begin
    hold_cur  = (state_q == SYNC) ? CW'(1) : cnt_q;
    hold_done = (hold_cur >= HOLD_END);
  end

  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      dom_q   <= '0;
      reset_q <= '1;
      ready_q <= 1'b0;
    end else if (state_q != SYNC && soft_req) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      dom_q   <= '0;
      reset_q <= '1;
      ready_q <= 1'b0;
    end else if ((state_q == SYNC && !sync_busy) || state_q == HOLD) begin
      if (!hold_done) begin
        state_q <= HOLD;
        cnt_q   <= hold_cur + CW'(1);
      end else if (STAGGERED) begin
        state_q    <= STAG;
        cnt_q      <= '0;
        dom_q      <= DW'(1);
        reset_q[0] <= 1'b0;
      end else begin
        state_q <= RUN;
        cnt_q   <= '0;
        reset_q <= '0;
        ready_q <= 1'b1;
      end
    end else if (state_q == STAG) begin
      if (cnt_q == STAG_END) begin
        cnt_q <= '0;
        for (int i = 0; i < NUM_RESETS; i++) begin
          if (dom_q == DW'(i)) reset_q[i] <= 1'b0;
        end
        if (dom_q == DOM_LAST) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end else begin
          dom_q <= dom_q + DW'(1);
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign reset = reset_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: staggered instance (2/4/3/2) and an all-together instance (2/4/4/0)
// share clk, key and soft_req; expected release edges are hand-derived from edge numbers.
module tb_reset_sequencer;

  localparam int SS = 2;
  localparam int HC = 4;
  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       key;
  logic       soft_req;
  logic [2:0] reset_a;
  logic       ready_a;
  logic [3:0] reset_b;
  logic       ready_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC), .NUM_RESETS(3), .STAGGER(ST)) dut_a (
    .clk(clk), .key(key), .soft_req(soft_req), .reset(reset_a), .ready(ready_a)
  );

  reset_sequencer #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC), .NUM_RESETS(4), .STAGGER(0)) dut_b (
    .clk(clk), .key(key), .soft_req(soft_req), .reset(reset_b), .ready(ready_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Bit i released at edge E(SS + HC + i*ST).
  function automatic logic [2:0] exp_a_key(input int k);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (k < SS + HC + i * ST);
    return v;
  endfunction

  // j counts edges after F (j = 0 is F itself); bit i released at F + HC + i*ST.
  function automatic logic [2:0] exp_a_soft(input int j);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (j < HC + i * ST);
    return v;
  endfunction

  task automatic check_async(input string tag);
    check({tag, "_rst_a"}, 32'(reset_a), 32'h7);
    check({tag, "_rdy_a"}, 32'(ready_a), 32'h0);
    check({tag, "_rst_b"}, 32'(reset_b), 32'hF);
    check({tag, "_rdy_b"}, 32'(ready_b), 32'h0);
  endtask

  // Caller raises key on a negedge; the next posedge is E1.
  task automatic run_key_seq(input string tag);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s_E%0d_rst_a", tag, k), 32'(reset_a), 32'(exp_a_key(k)));
      check($sformatf("%s_E%0d_rdy_a", tag, k), 32'(ready_a), 32'(k >= 10));
      check($sformatf("%s_E%0d_rst_b", tag, k), 32'(reset_b), (k < 6) ? 32'hF : 32'h0);
      check($sformatf("%s_E%0d_rdy_b", tag, k), 32'(ready_b), 32'(k >= 6));
    end
  endtask

  // Caller drops soft_req on a negedge; the next posedge is F.
  task automatic run_soft_seq(input string tag);
    for (int j = 0; j <= 10; j++) begin
      @(posedge clk); #1;
      check($sformatf("%s_F+%0d_rst_a", tag, j), 32'(reset_a), 32'(exp_a_soft(j)));
      check($sformatf("%s_F+%0d_rdy_a", tag, j), 32'(ready_a), 32'(j >= 8));
      check($sformatf("%s_F+%0d_rst_b", tag, j), 32'(reset_b), (j < 4) ? 32'hF : 32'h0);
      check($sformatf("%s_F+%0d_rdy_b", tag, j), 32'(ready_b), 32'(j >= 4));
    end
  endtask

  initial begin
    key      = 1'b1;
    soft_req = 1'b0;
    #1 key = 1'b0;
    #1 check_async("t1_por");

    // 1. Power-up: key low 3 cycles, then released.
    repeat (3) begin
      @(posedge clk); #1;
      check_async("t1_keylow");
    end
    @(negedge clk) key = 1'b1;
    run_key_seq("t1");

    // 2. Key asserted between edges while in RUN: clears before the next edge.
    @(posedge clk); #3 key = 1'b0;
    #1 check_async("t2_async");
    @(negedge clk);
    @(negedge clk) key = 1'b1;
    run_key_seq("t2");

    // 3. One-cycle soft request in RUN.
    @(negedge clk) soft_req = 1'b1;
    @(posedge clk); #1;
    check_async("t3_S");
    @(negedge clk) soft_req = 1'b0;
    run_soft_seq("t3");

    // 4. Soft request held for 10 cycles.
    @(negedge clk) soft_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_async($sformatf("t4_hold%0d", c));
    end
    @(negedge clk) soft_req = 1'b0;
    run_soft_seq("t4");

    // 5. Key pulse right after reset[0] falls in STAG; soft_req while in SYNC is ignored.
    @(negedge clk) key = 1'b0;
    @(negedge clk) key = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("t5_pre_E%0d_rst_a", k), 32'(reset_a), 32'(exp_a_key(k)));
    end
    #2 key = 1'b0;
    #1 check_async("t5_async");
    @(negedge clk);
    @(negedge clk) begin
      key      = 1'b1;
      soft_req = 1'b1;
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk) soft_req = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("t5_E%0d_rst_a", k), 32'(reset_a), 32'(exp_a_key(k)));
      check($sformatf("t5_E%0d_rdy_a", k), 32'(ready_a), 32'(k >= 10));
      check($sformatf("t5_E%0d_rst_b", k), 32'(reset_b), (k < 6) ? 32'hF : 32'h0);
    end

    // Monotonic release: nothing reasserts in RUN without key or soft_req.
    repeat (5) begin
      @(posedge clk); #1;
      check("run_stable_a", {28'h0, ready_a, reset_a}, 32'h8);
      check("run_stable_b", {27'h0, ready_b, reset_b}, 32'h10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
